// File: rtl/orbit_machine.sv
// orbit_machine: per-frame game-state controller for the orbital-vessel display.
// Sequences WELCOME -> FREE -> ORBIT -> LAUNCH, selects the captured planet,
// and produces the orbit angle plus a free-running moon angle.
// Ports:
//   frame_clk, Reset       frame clock, synchronous active-high reset
//   keycode[15:0]          two packed HID keycodes (ENTER = 0x28, SPACE = 0x2C)
//   PlanetnX/Y/S/M         centre, radius and mass (angular step) of planet n = 1..8
//   VesselX/Y/S            vessel centre and radius
//   state[1:0]             0 WELCOME, 1 FREE, 2 ORBIT, 3 LAUNCH
//   curplan[2:0]           current or last captured planet index (0 = Planet1)
//   welcomepage            high exactly while state is WELCOME
//   theta, moontheta       orbit and moon angles in degrees, 0..359
module orbit_machine (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [15:0]        keycode,
  input  logic signed [31:0] Planet1X, Planet1Y, Planet1S, Planet1M,
  input  logic signed [31:0] Planet2X, Planet2Y, Planet2S, Planet2M,
  input  logic signed [31:0] Planet3X, Planet3Y, Planet3S, Planet3M,
  input  logic signed [31:0] Planet4X, Planet4Y, Planet4S, Planet4M,
  input  logic signed [31:0] Planet5X, Planet5Y, Planet5S, Planet5M,
  input  logic signed [31:0] Planet6X, Planet6Y, Planet6S, Planet6M,
  input  logic signed [31:0] Planet7X, Planet7Y, Planet7S, Planet7M,
  input  logic signed [31:0] Planet8X, Planet8Y, Planet8S, Planet8M,
  input  logic signed [31:0] VesselX,
  input  logic signed [31:0] VesselY,
  input  logic signed [31:0] VesselS,
  output logic [1:0]         state,
  output logic [2:0]         curplan,
  output logic               welcomepage,
  output logic signed [31:0] theta,
  output logic signed [31:0] moontheta
);

  localparam int unsigned NPLAN = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned WW    = 64;

  typedef enum logic [1:0] {
    WELCOME = 2'd0,
    FREE    = 2'd1,
    ORBIT   = 2'd2,
    LAUNCH  = 2'd3
  } state_t;

  state_t st;

  logic signed [IW-1:0] px [NPLAN];
  logic signed [IW-1:0] py [NPLAN];
  logic signed [IW-1:0] ps [NPLAN];
  logic signed [IW-1:0] pm [NPLAN];

  assign px = '{Planet1X, Planet2X, Planet3X, Planet4X, Planet5X, Planet6X, Planet7X, Planet8X};
  assign py = '{Planet1Y, Planet2Y, Planet3Y, Planet4Y, Planet5Y, Planet6Y, Planet7Y, Planet8Y};
  assign ps = '{Planet1S, Planet2S, Planet3S, Planet4S, Planet5S, Planet6S, Planet7S, Planet8S};
  assign pm = '{Planet1M, Planet2M, Planet3M, Planet4M, Planet5M, Planet6M, Planet7M, Planet8M};

  // Circle-circle overlap; 64-bit signed keeps the squares from wrapping.
  function automatic logic overlap(input logic signed [IW-1:0] ax, input logic signed [IW-1:0] ay,
                                   input logic signed [IW-1:0] ar, input logic signed [IW-1:0] bx,
                                   input logic signed [IW-1:0] by, input logic signed [IW-1:0] br);
    logic signed [WW-1:0] dx, dy, rr;
    dx = WW'(ax) - WW'(bx);
    dy = WW'(ay) - WW'(by);
    rr = WW'(ar) + WW'(br);
    return (dx * dx + dy * dy) < (rr * rr);
  endfunction

  // Key decode; any unknown bit on keycode means no key.
  logic key_known, enter, space;
  always_comb begin
    key_known = ((^keycode) !== 1'bx);
    enter     = key_known && ((keycode[15:8] == 8'h28) || (keycode[7:0] == 8'h28));
    space     = key_known && ((keycode[15:8] == 8'h2C) || (keycode[7:0] == 8'h2C));
  end

  // Per-planet overlap and lowest-index hit (scan downward so the lowest wins).
  logic [NPLAN-1:0] ovl;
  logic             hit;
  logic [2:0]       hit_idx;
  always_comb begin
    ovl     = '0;
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 0; i < int'(NPLAN); i++) begin
      ovl[i] = overlap(VesselX, VesselY, VesselS, px[i], py[i], ps[i]);
    end
    for (int i = int'(NPLAN) - 1; i >= 0; i--) begin
      if (ovl[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // Next orbit angle: masses are below 360, so one conditional subtract suffices.
  logic signed [IW-1:0] theta_sum, theta_next;
  always_comb begin
    theta_sum  = theta + pm[curplan];
    theta_next = (theta_sum >= 32'sd360) ? (theta_sum - 32'sd360) : theta_sum;
  end

  // Game FSM with registered outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st          <= WELCOME;
      welcomepage <= 1'b1;
      curplan     <= 3'd0;
      theta       <= '0;
      moontheta   <= '0;
    end else begin
      moontheta <= (moontheta == 32'sd359) ? 32'sd0 : (moontheta + 32'sd1);
      case (st)
        WELCOME: begin
          if (enter) begin
            st          <= FREE;
            welcomepage <= 1'b0;
          end
        end
        FREE: begin
          if (hit) begin
            st      <= ORBIT;
            curplan <= hit_idx;
            theta   <= '0;
          end
        end
        ORBIT: begin
          if (space) st <= LAUNCH;
          else       theta <= theta_next;
        end
        LAUNCH: begin
          // Stay put until the vessel clears the planet it left, so a held SPACE
          // cannot cause an immediate recapture.
          if (!ovl[curplan]) st <= FREE;
        end
        default: begin
          st          <= WELCOME;
          welcomepage <= 1'b1;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_orbit_machine.sv
// tb_orbit_machine: directed self-checking bench for orbit_machine.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_orbit_machine;

  logic               frame_clk = 1'b0;
  logic               Reset;
  logic [15:0]        keycode;
  logic signed [31:0] px [8];
  logic signed [31:0] py [8];
  logic signed [31:0] ps [8];
  logic signed [31:0] pm [8];
  logic signed [31:0] vx, vy, vs;
  logic [1:0]         state;
  logic [2:0]         curplan;
  logic               welcomepage;
  logic signed [31:0] theta, moontheta;

  int tests = 0;
  int fails = 0;

  always #5 frame_clk = ~frame_clk;

  orbit_machine dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .Planet1X(px[0]), .Planet1Y(py[0]), .Planet1S(ps[0]), .Planet1M(pm[0]),
    .Planet2X(px[1]), .Planet2Y(py[1]), .Planet2S(ps[1]), .Planet2M(pm[1]),
    .Planet3X(px[2]), .Planet3Y(py[2]), .Planet3S(ps[2]), .Planet3M(pm[2]),
    .Planet4X(px[3]), .Planet4Y(py[3]), .Planet4S(ps[3]), .Planet4M(pm[3]),
    .Planet5X(px[4]), .Planet5Y(py[4]), .Planet5S(ps[4]), .Planet5M(pm[4]),
    .Planet6X(px[5]), .Planet6Y(py[5]), .Planet6S(ps[5]), .Planet6M(pm[5]),
    .Planet7X(px[6]), .Planet7Y(py[6]), .Planet7S(ps[6]), .Planet7M(pm[6]),
    .Planet8X(px[7]), .Planet8Y(py[7]), .Planet8S(ps[7]), .Planet8M(pm[7]),
    .VesselX(vx), .VesselY(vy), .VesselS(vs),
    .state(state), .curplan(curplan), .welcomepage(welcomepage),
    .theta(theta), .moontheta(moontheta)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (welcomepage !== 1'b1) begin fails++; $display("FAIL reset_welcome: got %0b want 1", welcomepage); end
    tests++; if (curplan !== 3'd0) begin fails++; $display("FAIL reset_curplan: got %0d want 0", curplan); end
    tests++; if (theta !== 32'sd0) begin fails++; $display("FAIL reset_theta: got %0d want 0", theta); end
    tests++; if (moontheta !== 32'sd0) begin fails++; $display("FAIL reset_moon: got %0d want 0", moontheta); end
    Reset = 1'b0;
    tick();
    tests++; if (moontheta !== 32'sd1) begin fails++; $display("FAIL moon_step1: got %0d want 1", moontheta); end
    tick();
    tests++; if (moontheta !== 32'sd2) begin fails++; $display("FAIL moon_step2: got %0d want 2", moontheta); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL idle_welcome: got %0d want 0", state); end
  endtask

  task automatic test_welcome();
    keycode = 16'h002C;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL welcome_space: got %0d want 0", state); end
    keycode = 16'h0028;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL welcome_enter: got %0d want 1", state); end
    tests++; if (welcomepage !== 1'b0) begin fails++; $display("FAIL welcome_page: got %0b want 0", welcomepage); end
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL free_enter_held: got %0d want 1", state); end
    keycode = 16'h0000;
  endtask

  task automatic test_capture();
    keycode = 16'h002C;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL free_space: got %0d want 1", state); end
    keycode = 16'h0000;
    vx = 350; vy = 250;
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL capture_state: got %0d want 2", state); end
    tests++; if (curplan !== 3'd0) begin fails++; $display("FAIL capture_curplan: got %0d want 0", curplan); end
    tests++; if (theta !== 32'sd0) begin fails++; $display("FAIL capture_theta: got %0d want 0", theta); end
    tick();
    tests++; if (theta !== 32'sd5) begin fails++; $display("FAIL orbit_theta5: got %0d want 5", theta); end
    tick();
    tests++; if (theta !== 32'sd10) begin fails++; $display("FAIL orbit_theta10: got %0d want 10", theta); end
    tick();
    tests++; if (theta !== 32'sd15) begin fails++; $display("FAIL orbit_theta15: got %0d want 15", theta); end
  endtask

  task automatic test_launch();
    keycode = 16'h002C;
    tick();
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL launch_state: got %0d want 3", state); end
    tests++; if (theta !== 32'sd15) begin fails++; $display("FAIL launch_theta_hold: got %0d want 15", theta); end
    tick();
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL launch_stay: got %0d want 3", state); end
    vx = 30; vy = 30;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL launch_separate: got %0d want 1", state); end
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL no_recapture: got %0d want 1", state); end
    tests++; if (curplan !== 3'd0) begin fails++; $display("FAIL curplan_hold: got %0d want 0", curplan); end
    keycode = 16'h0000;
  endtask

  task automatic test_planets();
    for (int n = 1; n < 8; n++) begin
      vx = px[n]; vy = py[n];
      tick();
      tests++; if (state !== 2'd2) begin fails++; $display("FAIL planet%0d_state: got %0d want 2", n + 1, state); end
      tests++; if (curplan !== 3'(n)) begin fails++; $display("FAIL planet%0d_curplan: got %0d want %0d", n + 1, curplan, n); end
      keycode = 16'h2C00;
      tick();
      tests++; if (state !== 2'd3) begin fails++; $display("FAIL planet%0d_launch: got %0d want 3", n + 1, state); end
      keycode = 16'h0000;
      vx = 30; vy = 30;
      tick();
      tests++; if (state !== 2'd1) begin fails++; $display("FAIL planet%0d_free: got %0d want 1", n + 1, state); end
    end
  endtask

  task automatic test_priority();
    px[0] = 100; py[0] = 100;
    vx = 100; vy = 100;
    tick();
    tests++; if (state !== 2'd2) begin fails++; $display("FAIL prio_state: got %0d want 2", state); end
    tests++; if (curplan !== 3'd0) begin fails++; $display("FAIL prio_curplan: got %0d want 0", curplan); end
    keycode = 16'h002C;
    tick();
    vx = 30; vy = 30;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL prio_free: got %0d want 1", state); end
    keycode = 16'h0000;
    px[0] = 350; py[0] = 250;
  endtask

  task automatic test_wrap();
    vx = 350; vy = 250;
    tick();
    tests++; if (theta !== 32'sd0) begin fails++; $display("FAIL wrap_capture: got %0d want 0", theta); end
    for (int k = 1; k <= 72; k++) begin
      tick();
      tests++;
      if (theta !== 32'((k * 5) % 360)) begin
        fails++; $display("FAIL wrap_theta_k%0d: got %0d want %0d", k, theta, (k * 5) % 360);
      end
    end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_orbit_state: got %0d want 0", state); end
    tests++; if (theta !== 32'sd0) begin fails++; $display("FAIL reset_orbit_theta: got %0d want 0", theta); end
    Reset = 1'b0;
    vx = 30; vy = 30;
    keycode = 16'h0028;
    tick();
    keycode = 16'h0000;
    vx = px[2]; vy = py[2];
    tick();
    keycode = 16'h002C;
    tick();
    tests++; if (state !== 2'd3 || curplan !== 3'd2) begin
      fails++; $display("FAIL pre_reset_launch: got state %0d plan %0d want 3 2", state, curplan);
    end
    Reset = 1'b1;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_launch_state: got %0d want 0", state); end
    tests++; if (curplan !== 3'd0) begin fails++; $display("FAIL reset_launch_curplan: got %0d want 0", curplan); end
    tests++; if (welcomepage !== 1'b1) begin fails++; $display("FAIL reset_launch_welcome: got %0b want 1", welcomepage); end
    keycode = 16'h0000;
  endtask

  task automatic test_moon_wrap();
    Reset = 1'b0;
    for (int k = 0; k < 359; k++) tick();
    tests++; if (moontheta !== 32'sd359) begin fails++; $display("FAIL moon_359: got %0d want 359", moontheta); end
    tick();
    tests++; if (moontheta !== 32'sd0) begin fails++; $display("FAIL moon_wrap: got %0d want 0", moontheta); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL welcome_overlap_ignored: got %0d want 0", state); end
  endtask

  initial begin
    Reset   = 1'b1;
    keycode = 16'h0000;
    px = '{350, 100, 420, 500, 580, 540, 180, 100};
    py = '{250, 100,  50, 340, 380, 110, 200, 400};
    ps = '{ 10,  20,  12,  19,   8,  24,  18,  10};
    pm = '{  5,   7,   7,   7,   7,   7,   7,   7};
    vx = 30; vy = 30; vs = 10;
    #2;
    test_reset();
    test_welcome();
    test_capture();
    test_launch();
    test_planets();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_moon_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
